ccff_chain_loader: RTL and testbench

Bitstream loader that drives the configuration-chain head (`ccff_head`) of a routing tile such as a switch block and reads the chain tail (`ccff_tail`) back for verification. It accepts configuration bytes over a valid/ready stream and serialises them into the flip-flop chain, one bit per enabled `prog_clk` edge. It can optionally recirculate the chain to check its contents non-destructively with a CRC-8. It sits between the bitstream source and the first `*_mem` block of a tile's chain.

---
 rtl/ccff_chain_loader_pkg.sv | 23 ++
 rtl/ccff_chain_loader_if.sv | 12 +
 rtl/ccff_crc8_serial.sv | 21 ++
 rtl/ccff_chain_loader.sv | 129 ++++++++++++
 tb/tb_ccff_chain_loader.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/ccff_chain_loader_pkg.sv
// Shared types and constants for the configuration-chain loader.
// The package name is ccff_pkg; the file name follows the block's own prefix.
package ccff_pkg;

    localparam int         CCFF_BYTE_W   = 8;
    localparam logic [7:0] CCFF_CRC_POLY = 8'h07;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_SHIFT,
        ST_VERIFY,
        ST_DONE
    } ccff_state_t;

    // One serial CRC-8 step, MSB-first feedback, zero init.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
        logic fb;
        fb = crc[7] ^ bit_in;
        return {crc[6:0], 1'b0} ^ (fb ? CCFF_CRC_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/ccff_chain_loader_if.sv
// Bitstream byte stream between the bitstream source and the chain loader.
interface ccff_chain_loader_if;
    import ccff_pkg::*;

    logic [CCFF_BYTE_W-1:0] bs_data;
    logic                   bs_valid;
    logic                   bs_ready;

    modport master (output bs_data, output bs_valid, input bs_ready);
    modport slave  (input bs_data, input bs_valid, output bs_ready);

endinterface

// File: rtl/ccff_crc8_serial.sv
// Bit-serial CRC-8 accumulator with synchronous clear and enable.
module ccff_crc8_serial
    import ccff_pkg::*;
(
    input  logic       prog_clk,
    input  logic       pReset,
    input  logic       clr,
    input  logic       en,
    input  logic       bit_in,
    output logic [7:0] crc
);

    always_ff @(posedge prog_clk) begin
        if (pReset || clr) begin
            crc <= 8'h00;
        end else if (en) begin
            crc <= crc8_step(crc, bit_in);
        end
    end

endmodule

// File: rtl/ccff_chain_loader.sv
// Serialises stream bytes LSB-first into a configuration flip-flop chain and
// optionally recirculates the chain once to compare load and readback CRCs.
module ccff_chain_loader
    import ccff_pkg::*;
#(
    parameter int CHAIN_LEN = 30,
    parameter int BYTE_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic                 prog_clk,
    input  logic                 pReset,
    input  logic                 start,
    input  logic                 verify_en,
    ccff_chain_loader_if.slave   bs,
    output logic                 ccff_head,
    input  logic                 ccff_tail,
    output logic                 chain_shift_en,
    output logic                 busy,
    output logic                 done,
    output logic                 verify_ok,
    output logic                 verify_err,
    output logic [CNT_W-1:0]     bit_count
);

    ccff_state_t       state;
    logic [BYTE_W-1:0] shreg;
    logic [3:0]        nbits;
    logic              verify_q;
    logic [7:0]        crc_load;
    logic [7:0]        crc_rb;

    // Bits still owed to the chain, capped at one byte.
    function automatic logic [3:0] clamp_nbits(input int remaining);
        if (remaining >= BYTE_W) return 4'(BYTE_W);
        return 4'(remaining);
    endfunction

    assign bs.bs_ready      = (state == ST_FETCH);
    assign chain_shift_en   = (state == ST_SHIFT) || (state == ST_VERIFY);
    assign busy             = (state != ST_IDLE);
    assign done             = (state == ST_DONE);
    assign ccff_head        = (state == ST_SHIFT)  ? shreg[0] :
                              (state == ST_VERIFY) ? ccff_tail : 1'b0;

    ccff_crc8_serial u_crc_load (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .clr      ((state == ST_IDLE) && start),
        .en       (state == ST_SHIFT),
        .bit_in   (shreg[0]),
        .crc      (crc_load)
    );

    ccff_crc8_serial u_crc_rb (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .clr      ((state == ST_IDLE) && start),
        .en       (state == ST_VERIFY),
        .bit_in   (ccff_tail),
        .crc      (crc_rb)
    );

    // Byte shift register is pure data and needs no reset.
    always_ff @(posedge prog_clk) begin
        if ((state == ST_FETCH) && bs.bs_valid) begin
            shreg <= bs.bs_data;
        end else if (state == ST_SHIFT) begin
            shreg <= shreg >> 1;
        end
    end

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state      <= ST_IDLE;
            nbits      <= 4'd0;
            verify_q   <= 1'b0;
            bit_count  <= '0;
            verify_ok  <= 1'b0;
            verify_err <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state      <= ST_FETCH;
                        verify_q   <= verify_en;
                        bit_count  <= '0;
                        verify_ok  <= 1'b0;
                        verify_err <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    if (bs.bs_valid) begin
                        nbits <= clamp_nbits(CHAIN_LEN - int'(bit_count));
                        state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    nbits     <= nbits - 4'd1;
                    bit_count <= bit_count + CNT_W'(1);
                    if (nbits == 4'd1) begin
                        if (int'(bit_count) + 1 < CHAIN_LEN) begin
                            state <= ST_FETCH;
                        end else if (verify_q) begin
                            state     <= ST_VERIFY;
                            bit_count <= '0;
                        end else begin
                            state <= ST_DONE;
                        end
                    end
                end
                ST_VERIFY: begin
                    bit_count <= bit_count + CNT_W'(1);
                    if (int'(bit_count) == CHAIN_LEN - 1) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    if (verify_q) begin
                        verify_ok  <= (crc_load == crc_rb);
                        verify_err <= (crc_load != crc_rb);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Self-checking bench: behavioural 30-bit chain model plus directed and random loads.
module tb_ccff_chain_loader;
    import ccff_pkg::*;

    localparam int CHAIN_LEN = 30;
    localparam int CNT_W     = 5;

    logic             prog_clk = 1'b0;
    logic             pReset   = 1'b1;
    logic             start    = 1'b0;
    logic             verify_en = 1'b0;
    logic             ccff_head;
    logic             ccff_tail;
    logic             chain_shift_en;
    logic             busy;
    logic             done;
    logic             verify_ok;
    logic             verify_err;
    logic [CNT_W-1:0] bit_count;

    ccff_chain_loader_if bs_if ();

    ccff_chain_loader #(.CHAIN_LEN(CHAIN_LEN)) dut (
        .prog_clk       (prog_clk),
        .pReset         (pReset),
        .start          (start),
        .verify_en      (verify_en),
        .bs             (bs_if),
        .ccff_head      (ccff_head),
        .ccff_tail      (ccff_tail),
        .chain_shift_en (chain_shift_en),
        .busy           (busy),
        .done           (done),
        .verify_ok      (verify_ok),
        .verify_err     (verify_err),
        .bit_count      (bit_count)
    );

    always #5 prog_clk = ~prog_clk;

    // Chain model: index 0 sits next to the head, index 29 drives the tail.
    logic [CHAIN_LEN-1:0] chain     = '0;
    logic [CHAIN_LEN-1:0] flip_mask = '0;
    always @(posedge prog_clk) begin
        if (pReset) chain <= '0;
        else if (chain_shift_en) chain <= {chain[CHAIN_LEN-2:0], ccff_head} ^ flip_mask;
    end
    assign ccff_tail = chain[CHAIN_LEN-1];

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [7:0] bytes[4];
    int         stall_cnt[4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Stream bit i lands i positions from the far end after the full load.
    function automatic logic [CHAIN_LEN-1:0] exp_chain();
        logic [CHAIN_LEN-1:0] r;
        for (int i = 0; i < CHAIN_LEN; i++) r[CHAIN_LEN-1-i] = bytes[i/8][i%8];
        return r;
    endfunction

    task automatic run_load(input string tag, input logic vfy, input int fault_cycle,
                            input int mid_start);
        int n, j, left, s_total, exp_done;
        logic got;
        s_total = 0;
        for (int k = 0; k < 4; k++) s_total += stall_cnt[k];
        exp_done = 35 + s_total + (vfy ? 30 : 0);
        start = 1'b1; verify_en = vfy;
        @(posedge prog_clk); #1;
        start = 1'b0; verify_en = 1'b0;
        n = 1; j = 0; left = stall_cnt[0]; got = 1'b0;
        while (n <= 200) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            bs_if.bs_valid = 1'b0;
            if (bs_if.bs_ready && j < 4) begin
                if (left > 0) begin
                    left--;
                    chk({tag, "_stall_shift_en"}, 32'(chain_shift_en), 32'd0);
                end else begin
                    bs_if.bs_valid = 1'b1;
                    bs_if.bs_data  = bytes[j];
                    j++;
                    if (j < 4) left = stall_cnt[j];
                end
            end
            if (n == fault_cycle) flip_mask = 30'h1 << 12;
            if (n == mid_start) start = 1'b1;
            @(posedge prog_clk); #1;
            flip_mask = '0; start = 1'b0; n++;
        end
        bs_if.bs_valid = 1'b0;
        chk({tag, "_done_cycle"}, got ? 32'(n) : 32'd0, 32'(exp_done));
        if (got) begin
            chk({tag, "_bit_count"}, 32'(bit_count), 32'(CHAIN_LEN));
            @(posedge prog_clk); #1;
            chk({tag, "_busy_after"}, 32'(busy), 32'd0);
            chk({tag, "_done_pulse"}, 32'(done), 32'd0);
            chk({tag, "_verify_ok"}, 32'(verify_ok), 32'(vfy && fault_cycle == 0));
            chk({tag, "_verify_err"}, 32'(verify_err), 32'(vfy && fault_cycle != 0));
            if (fault_cycle == 0) chk({tag, "_chain"}, 32'(chain), 32'(exp_chain()));
        end
    endtask

    initial begin
        int k;
        bs_if.bs_valid = 1'b0;
        bs_if.bs_data  = 8'h00;
        for (int i = 0; i < 4; i++) stall_cnt[i] = 0;

        // Reset held for three cycles.
        repeat (3) @(posedge prog_clk);
        #1;
        chk("rst_bs_ready", 32'(bs_if.bs_ready), 32'd0);
        chk("rst_shift_en", 32'(chain_shift_en), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_flags", {30'd0, verify_ok, verify_err}, 32'd0);
        chk("rst_bit_count", 32'(bit_count), 32'd0);
        chk("rst_head", 32'(ccff_head), 32'd0);
        pReset = 1'b0;
        @(posedge prog_clk); #1;

        bytes[0] = 8'hA5; bytes[1] = 8'h3C; bytes[2] = 8'hFF; bytes[3] = 8'h15;
        run_load("load", 1'b0, 0, 0);
        run_load("verify", 1'b1, 0, 0);
        run_load("fault", 1'b1, 40, 0);
        stall_cnt[3] = 5;
        run_load("stall", 1'b0, 0, 0);
        stall_cnt[3] = 0;

        // Reset mid-shift abandons the load.
        start = 1'b1;
        @(posedge prog_clk); #1;
        start = 1'b0;
        k = 0;
        while (bit_count != 5'd11 && k < 100) begin
            bs_if.bs_valid = 1'b1;
            bs_if.bs_data  = 8'($urandom);
            @(posedge prog_clk); #1;
            k++;
        end
        chk("mid_reach_11", 32'(bit_count), 32'd11);
        chk("mid_shifting", 32'(chain_shift_en), 32'd1);
        bs_if.bs_valid = 1'b0;
        pReset = 1'b1;
        @(posedge prog_clk); #1;
        pReset = 1'b0;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_bit_count", 32'(bit_count), 32'd0);
        run_load("after_rst", 1'b0, 0, 10);
        run_load("after_rst_vfy", 1'b1, 0, 20);

        // Random bytes, random source stalls, random verify selection.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 4; i++) begin
                bytes[i]     = 8'($urandom);
                stall_cnt[i] = $urandom_range(0, 3);
            end
            run_load($sformatf("rand%0d", r), 1'($urandom_range(0, 1)), 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
